// File: rtl/syst_chain_ctrl.sv
// Sequencing controller for a linear chain of MAC nodes computing y = W * x.
// Buffers x from a stream, skews per-node valids/rows, and drains tail results.
module syst_chain_ctrl #(
  parameter int unsigned N        = 8,
  parameter int unsigned ROWS     = 8,
  parameter int unsigned X_WIDTH  = 16,
  parameter int unsigned SO_WIDTH = 32,
  parameter int unsigned ROW_W    = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [X_WIDTH-1:0]    s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [N*X_WIDTH-1:0]  node_x_o,
  output logic [N-1:0]          node_x_valid_o,
  output logic [N*ROW_W-1:0]    node_row_o,
  output logic                  chain_enable_o,
  input  logic [SO_WIDTH-1:0]   chain_tail_psumm_i,
  input  logic                  chain_tail_valid_i,
  output logic [SO_WIDTH-1:0]   res_data_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i
);

  localparam int unsigned LdW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ResW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CycW = $clog2(ROWS + N + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [LdW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [CycW-1:0]    cyc_q, cyc_d;
  logic [ResW-1:0]    res_cnt_q, res_cnt_d;
  logic [X_WIDTH-1:0] xbuf_q [N];

  logic run;
  logic accept_x;
  logic accept_res;

  assign run        = (state_q == StRun);
  assign accept_x   = (state_q == StLoad) && s_valid_i;
  assign accept_res = res_valid_o && res_ready_i;

  assign busy_o         = (state_q != StIdle);
  assign done_o         = (state_q == StDone);
  assign s_ready_o      = (state_q == StLoad);
  // A presented but unaccepted result freezes the whole chain, cyc included.
  assign chain_enable_o = run && !(chain_tail_valid_i && !res_ready_i);
  assign res_data_o     = chain_tail_psumm_i;
  assign res_valid_o    = run && chain_tail_valid_i;

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    cyc_d     = cyc_q;
    res_cnt_d = res_cnt_q;
    case (state_q)
      StIdle: begin
        ld_cnt_d = '0;
        if (start_i) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (accept_x) begin
          if (ld_cnt_q == LdW'(N - 1)) begin
            ld_cnt_d  = '0;
            cyc_d     = '0;
            res_cnt_d = '0;
            state_d   = StRun;
          end else begin
            ld_cnt_d = ld_cnt_q + LdW'(1);
          end
        end
      end
      StRun: begin
        if (chain_enable_o) begin
          cyc_d = cyc_q + CycW'(1);
        end
        if (accept_res) begin
          if (res_cnt_q == ResW'(ROWS - 1)) begin
            res_cnt_d = '0;
            state_d   = StDone;
          end else begin
            res_cnt_d = res_cnt_q + ResW'(1);
          end
        end
      end
      StDone: begin
        cyc_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      ld_cnt_q  <= '0;
      cyc_q     <= '0;
      res_cnt_q <= '0;
      for (int k = 0; k < int'(N); k++) begin
        xbuf_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      cyc_q     <= cyc_d;
      res_cnt_q <= res_cnt_d;
      if (accept_x) begin
        xbuf_q[ld_cnt_q] <= s_data_i;
      end
    end
  end

  // Node k lags node 0 by k enabled cycles; it works on row cyc-k while in window.
  always_comb begin
    int diff;
    diff           = 0;
    node_x_o       = '0;
    node_x_valid_o = '0;
    node_row_o     = '0;
    for (int k = 0; k < int'(N); k++) begin
      node_x_o[k*X_WIDTH +: X_WIDTH] = xbuf_q[k];
      diff = int'(cyc_q) - k;
      if (run && (diff >= 0) && (diff < int'(ROWS))) begin
        node_x_valid_o[k]            = 1'b1;
        node_row_o[k*ROW_W +: ROW_W] = ROW_W'(diff);
      end
    end
  end

endmodule

// File: tb/tb_syst_chain_ctrl.sv
// Bench for syst_chain_ctrl: N=ROWS=4 with behavioural MAC nodes and a W[r][k]=r+k ROM.
// Results are scoreboarded against a reference matrix-vector product.
module tb_syst_chain_ctrl;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int XW = 16;
  localparam int SW = 32;
  localparam int RW = 2;

  logic            clk;
  logic            rstn;
  logic            start;
  logic            busy;
  logic            done;
  logic [XW-1:0]   s_data;
  logic            s_valid;
  logic            s_ready;
  logic [N*XW-1:0] node_x;
  logic [N-1:0]    node_x_valid;
  logic [N*RW-1:0] node_row;
  logic            chain_enable;
  logic [SW-1:0]   tail_psumm;
  logic            tail_valid;
  logic [SW-1:0]   res_data;
  logic            res_valid;
  logic            res_ready;

  syst_chain_ctrl #(
    .N       (N),
    .ROWS    (R),
    .X_WIDTH (XW),
    .SO_WIDTH(SW)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .start_i           (start),
    .busy_o            (busy),
    .done_o            (done),
    .s_data_i          (s_data),
    .s_valid_i         (s_valid),
    .s_ready_o         (s_ready),
    .node_x_o          (node_x),
    .node_x_valid_o    (node_x_valid),
    .node_row_o        (node_row),
    .chain_enable_o    (chain_enable),
    .chain_tail_psumm_i(tail_psumm),
    .chain_tail_valid_i(tail_valid),
    .res_data_o        (res_data),
    .res_valid_o       (res_valid),
    .res_ready_i       (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int tcyc     = 0;
  int base     = 0;

  always @(posedge clk) tcyc <= tcyc + 1;

  // Behavioural MAC chain, frozen while chain_enable is low.
  logic [SW-1:0] ps [N];
  logic          pv [N];

  always @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < N; k++) begin
        ps[k] <= '0;
        pv[k] <= 1'b0;
      end
    end else if (chain_enable) begin
      pv[0] <= node_x_valid[0];
      ps[0] <= 32'(node_row[RW-1:0]) * 32'(node_x[XW-1:0]);
      for (int k = 1; k < N; k++) begin
        pv[k] <= node_x_valid[k];
        ps[k] <= ps[k-1] + 32'(k + int'(node_row[k*RW +: RW])) * 32'(node_x[k*XW +: XW]);
      end
    end
  end

  assign tail_psumm = ps[N-1];
  assign tail_valid = pv[N-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [SW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got result %0d at cycle %0d, want none", res_data,
                 tcyc - base);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", 64'(res_data), 64'(e.data));
        chk("res_cycle", 64'(tcyc - base), 64'(e.cyc));
      end
    end
  end

  // Skew table indexed by enabled RUN cycle count.
  typedef struct {
    logic [N-1:0]    xv;
    logic [N*RW-1:0] row;
    logic            rv;
  } vec_t;

  vec_t tbl [8];

  task automatic do_run(input logic [N*XW-1:0] xv, input bit tog, input bit stall,
                        input bit glitch, input bit abort);
    int run_start;
    int done_c;
    int abort_c;
    int end_c;
    int ld;
    int ecyc;
    int acc_c [R];
    logic [SW-1:0] y;
    logic in_run;
    logic exp_en;
    exp_t e;
    run_start = tog ? 8 : 5;
    for (int r = 0; r < R; r++) begin
      acc_c[r] = run_start + N + r + ((stall && r >= 1) ? 3 : 0);
    end
    done_c  = acc_c[R-1] + 1;
    abort_c = run_start + 5;
    end_c   = abort ? abort_c + 1 : done_c + 1;
    @(posedge clk);
    #1;
    base = tcyc;
    for (int r = 0; r < R; r++) begin
      y = '0;
      for (int k = 0; k < N; k++) begin
        y = y + 32'(r + k) * 32'(xv[k*XW +: XW]);
      end
      e.data = y;
      e.cyc  = acc_c[r];
      if (!abort || acc_c[r] <= abort_c) sb.push_back(e);
    end
    ld   = 0;
    ecyc = 0;
    for (int c = 0; c <= end_c; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      start     = (c == 0) || (glitch && (c == 2 || c == run_start + 2));
      s_valid   = (c >= 1) && (c < run_start) && (!tog || (c % 2 == 1));
      s_data    = s_valid ? xv[ld*XW +: XW] : 16'hdead;
      res_ready = !(stall && c >= 10 && c <= 12);
      rstn      = !(abort && c == abort_c);
      @(negedge clk);
      in_run = (c >= run_start) && (c <= acc_c[R-1]) && !(abort && c > abort_c);
      if (abort && c == abort_c + 1) begin
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_s_ready", 64'(s_ready), 64'(0));
        chk("abort_xvalid", 64'(node_x_valid), 64'(0));
        chk("abort_row", 64'(node_row), 64'(0));
        chk("abort_enable", 64'(chain_enable), 64'(0));
        chk("abort_res_valid", 64'(res_valid), 64'(0));
        chk("abort_node_x", 64'(node_x), 64'(0));
      end else begin
        chk("busy", 64'(busy), 64'((c >= 1) && (c <= done_c)));
        chk("done", 64'(done), 64'(c == done_c));
        chk("s_ready", 64'(s_ready), 64'((c >= 1) && (c < run_start)));
        exp_en = in_run && !(stall && c >= 10 && c <= 12);
        chk("chain_enable", 64'(chain_enable), 64'(exp_en));
        if (in_run && ecyc < 8) begin
          chk("node_x_valid", 64'(node_x_valid), 64'(tbl[ecyc].xv));
          chk("node_row", 64'(node_row), 64'(tbl[ecyc].row));
          chk("res_valid", 64'(res_valid), 64'(tbl[ecyc].rv));
          chk("node_x", 64'(node_x), 64'(xv));
        end
        if (exp_en) ecyc++;
      end
      if (s_valid && c >= 1 && c < run_start) ld++;
    end
    start     = 1'b0;
    s_valid   = 1'b0;
    res_ready = 1'b1;
    rstn      = 1'b1;
    chk("sb_drained", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  initial begin
    logic [N*XW-1:0] xr;
    tbl[0] = '{xv: 4'b0001, row: 8'h00, rv: 1'b0};
    tbl[1] = '{xv: 4'b0011, row: 8'h01, rv: 1'b0};
    tbl[2] = '{xv: 4'b0111, row: 8'h06, rv: 1'b0};
    tbl[3] = '{xv: 4'b1111, row: 8'h1b, rv: 1'b0};
    tbl[4] = '{xv: 4'b1110, row: 8'h6c, rv: 1'b1};
    tbl[5] = '{xv: 4'b1100, row: 8'hb0, rv: 1'b1};
    tbl[6] = '{xv: 4'b1000, row: 8'hc0, rv: 1'b1};
    tbl[7] = '{xv: 4'b0000, row: 8'h00, rv: 1'b1};

    rstn      = 1'b0;
    start     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_xvalid", 64'(node_x_valid), 64'(0));
    chk("rst_row", 64'(node_row), 64'(0));
    chk("rst_enable", 64'(chain_enable), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_node_x", 64'(node_x), 64'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    do_run({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b0, 1'b0, 1'b0);
    do_run({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b1, 1'b0, 1'b0);
    do_run({16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 1'b0, 1'b0, 1'b0);
    do_run({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b0, 1'b1, 1'b0);
    do_run({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b0, 1'b0, 1'b1);
    do_run({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < N; k++) xr[k*XW +: XW] = 16'($urandom);
      do_run(xr, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/syst_chain_ctrl.md
Name: syst_chain_ctrl

Overview:
- Sequencing controller for a linear chain of N syst_node-style MAC nodes computing y[r] = sum_k W[r][k]*x[k] for r = 0..ROWS-1 (DFT/FFT matrix-vector stage).
- Loads the x vector from a stream into a local buffer.
- During the run it drives each node's x operand and valid with a k-cycle skew, and gives the external weight ROM a per-node row index.
- Holds the chain enable low under result backpressure, and counts tail results until the run completes.

Parameters:
N, 8, number of chained nodes (vector length)
ROWS, 8, number of output rows per run
X_WIDTH, 16, sample width
SO_WIDTH, 32, partial-sum / result width
ROW_W, $clog2(ROWS), row index width (derived)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start  in  1  begin run (sampled in IDLE only)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of run
s_data  in  X_WIDTH  input sample
s_valid  in  1  sample valid
s_ready  out  1  high in LOAD
node_x  out  N*X_WIDTH  x operand per node, slice k = x[k]
node_x_valid  out  N  per-node x valid (also psumm valid for node 0)
node_row  out  N*ROW_W  weight ROM row index per node
chain_enable  out  1  enable to all nodes
chain_tail_psumm  in  SO_WIDTH  psumm_o of node N-1
chain_tail_valid  in  1  valid_o of node N-1
res_data  out  SO_WIDTH  result
res_valid  out  1  result valid
res_ready  in  1  downstream accept

Behaviour:
- Reset (rstn=0 at posedge): state IDLE, load/cycle/result counters 0, xbuf cleared to 0. All outputs 0: busy, done, s_ready, node_x_valid, node_row, chain_enable, res_valid.
- Reset mid-run aborts immediately. No partial done. Nodes share the same rstn.
- FSM: IDLE -> LOAD -> RUN -> DONE -> IDLE.
  - IDLE: start=1 -> LOAD next cycle.
  - LOAD: s_ready=1. Each s_valid&s_ready writes xbuf[ld_cnt] and increments ld_cnt. Gaps in s_valid are allowed. The N-th accept moves to RUN next cycle and clears ld_cnt.
  - RUN: cyc counter starts at 0 and increments only on cycles where chain_enable=1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- node_x[k] = xbuf[k], constant during RUN.
- node_x_valid[k] = RUN & (cyc >= k) & (cyc - k < ROWS).
- node_row[k] = cyc - k, truncated to ROW_W. Value is don't-care when node_x_valid[k]=0; drive 0.
- Node 0 psumm_i is tied to 0 externally. Its valid_psumm_i = node_x_valid[0].
- chain_enable = RUN & ~(chain_tail_valid & ~res_ready). A stall freezes the whole chain and cyc; node_x_valid and node_row hold their values.
- res_data = chain_tail_psumm. res_valid = RUN & chain_tail_valid (combinational pass-through).
- Result r appears at cyc = r + N, counting enabled cycles only.
- res_cnt increments on each res_valid & res_ready. The ROWS-th accept moves RUN -> DONE.
- Enable stays high through the drain, so node valids flush to 0 by the time the run completes.
- Width: cyc holds 0..ROWS+N. No arithmetic saturation in this block.

Test Plan:
- N=4, ROWS=4, x=[1,2,3,4], bench ROM W[r][k]=r+k, node models, res_ready=1. start at cycle 0; samples accepted cycles 1-4; RUN from cycle 5. Required: res_valid at cycles 9, 10, 11, 12 with data 20, 30, 40, 50; done pulse at cycle 13; busy low at cycle 14.
- Same run with res_ready=0 for 3 cycles while result 30 is presented. Required: res_data held at 30, chain_enable=0 and node_row frozen for those 3 cycles; all results 20/30/40/50 delivered; done moves to cycle 16.
- s_valid toggling 1,0,1,0,... during LOAD. Required: exactly 4 samples captured, in order; RUN entered the cycle after the 4th accept; results unchanged.
- start pulsed during LOAD and RUN. Required: ignored, no restart, single done pulse.
- rstn=0 for one cycle at RUN cyc=5. Required: next cycle all outputs 0 and state IDLE. A fresh start then produces correct results 20/30/40/50.
- Skew check: at RUN cyc=3, node_x_valid=4'b1111 and node_row = {0,1,2,3} for k=3..0. At cyc=6, node_x_valid=4'b1000 and node_row[3]=3.
